if_fetch_stage: RTL and testbench

- Instruction fetch stage directly upstream of the decode stage; produces IF_ID_pc, IF_ID_inst and IF_ID_vld.
- Owns the PC and drives an in-order instruction-memory request/response port.
- Buffers returned words in a small fetch queue to absorb decode stalls.
- Accepts taken-branch/jump redirects from EX, discarding wrong-path fetches that are still in flight.

---
 rtl/if_fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch stage with PC, credit-limited imem port, fetch queue and redirect flush
// Ports:
//   clk, rst            clock and synchronous active-low reset
//   ID_stall            decode cannot accept; IF_ID outputs hold
//   EX_br_taken/target  redirect from EX (target bits [1:0] ignored)
//   imem_req/addr/gnt   in-order instruction-memory request channel
//   imem_rvld/rdata     in-order response channel (latency >= 1)
//   IF_ID_pc/inst/vld   instruction handed to decode
//   IF_ID_pred          early-JAL marker (only with IF_JAL_PREDICT_EN)
// Optional macro: IF_JAL_PREDICT_EN enables early JAL redirect from the queue head.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_stall,
    input  logic        EX_br_taken,
    input  logic [31:0] EX_br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvld,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
`ifdef IF_JAL_PREDICT_EN
    output logic        IF_ID_pred,
`endif
    output logic        IF_ID_vld
);
    localparam int          AW      = $clog2(QDEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(QDEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [AW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [CW-1:0] q_cnt_q, q_cnt_d;
    logic [31:0]   tag_mem [QDEPTH];
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_inst  [QDEPTH];
    logic [31:0]   if_pc_q, if_pc_d, if_inst_q, if_inst_d;
    logic          if_vld_q, if_vld_d;

    logic          q_empty, pop, push, fire, rsp_vld, redirect, jal_redir, credit_ok;
    logic [CW-1:0] inflight;
    logic [31:0]   head_pc, head_inst, redir_pc;

    assign q_empty   = q_cnt_q == '0;
    assign head_pc   = q_pc[q_rd_q];
    assign head_inst = q_inst[q_rd_q];
    assign pop       = !EX_br_taken && !ID_stall && !q_empty;

`ifdef IF_JAL_PREDICT_EN
    logic [31:0] jal_tgt;
    logic        if_pred_q, if_pred_d;
    assign jal_tgt   = head_pc + {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                                  head_inst[20], head_inst[30:21], 1'b0};
    // The JAL is still handed to decode; only the entries behind it are flushed.
    assign jal_redir = pop && head_inst[6:0] == 7'b1101111;
    assign redir_pc  = EX_br_taken ? (EX_br_target & ~32'h3) : (jal_tgt & ~32'h3);
    assign if_pred_d = EX_br_taken ? 1'b0 : ID_stall ? if_pred_q : jal_redir;
    assign IF_ID_pred = if_pred_q;
`else
    assign jal_redir = 1'b0;
    assign redir_pc  = EX_br_target & ~32'h3;
`endif

    assign redirect  = EX_br_taken || jal_redir;
    // Outside FLUSH drop_q is zero, inside FLUSH out_q is zero, so the sum is
    // always the number of requests still in flight.
    assign inflight  = out_q + drop_q;
    assign rsp_vld   = imem_rvld && inflight != '0;
    assign credit_ok = ({1'b0, out_q} + {1'b0, q_cnt_q}) < CREDITS;
    assign fire      = imem_req && imem_gnt;
    assign push      = state_q == RUN && rsp_vld && !redirect;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = redirect ? (drop_d != '0 ? FLUSH : RUN)
                : state_q == IDLE ? RUN
                : (state_q == FLUSH && drop_d == '0) ? RUN
                : state_q;
    end

    // Output logic
    always_comb begin
        imem_req  = state_q == RUN && !redirect && credit_ok;
        imem_addr = pc_q;
    end

    // Datapath next-state
    always_comb begin
        pc_d      = redirect ? redir_pc : fire ? pc_q + 32'd4 : pc_q;
        out_d     = redirect ? '0 : out_q + CW'(fire) - CW'(push);
        // A response arriving in the redirect cycle is already accounted for.
        drop_d    = redirect ? inflight - CW'(rsp_vld) : drop_q - CW'(state_q == FLUSH && rsp_vld);
        tag_wr_d  = redirect ? '0 : tag_wr_q + AW'(fire);
        tag_rd_d  = redirect ? '0 : tag_rd_q + AW'(push);
        q_wr_d    = redirect ? '0 : q_wr_q + AW'(push);
        q_rd_d    = redirect ? '0 : q_rd_q + AW'(pop);
        q_cnt_d   = redirect ? '0 : q_cnt_q + CW'(push) - CW'(pop);
        if_vld_d  = EX_br_taken ? 1'b0 : ID_stall ? if_vld_q : !q_empty;
        if_inst_d = EX_br_taken ? NOP : ID_stall ? if_inst_q : q_empty ? NOP : head_inst;
        if_pc_d   = pop ? head_pc : if_pc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            out_q     <= '0;
            drop_q    <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            q_wr_q    <= '0;
            q_rd_q    <= '0;
            q_cnt_q   <= '0;
            if_pc_q   <= RESET_PC;
            if_inst_q <= NOP;
            if_vld_q  <= 1'b0;
`ifdef IF_JAL_PREDICT_EN
            if_pred_q <= 1'b0;
`endif
        end else begin
            pc_q      <= pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            q_wr_q    <= q_wr_d;
            q_rd_q    <= q_rd_d;
            q_cnt_q   <= q_cnt_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
            if_vld_q  <= if_vld_d;
`ifdef IF_JAL_PREDICT_EN
            if_pred_q <= if_pred_d;
`endif
        end
    end

    // Storage arrays need no reset: pointers and counts decide what is live.
    always_ff @(posedge clk) begin
        if (fire) tag_mem[tag_wr_q] <= pc_q;
        if (push) begin
            q_pc[q_wr_q]   <= tag_mem[tag_rd_q];
            q_inst[q_wr_q] <= imem_rdata;
        end
    end

    assign IF_ID_pc   = if_pc_q;
    assign IF_ID_inst = if_inst_q;
    assign IF_ID_vld  = if_vld_q;

    a_rvld_has_credit: assert property (@(posedge clk) disable iff (!rst) !(imem_rvld && inflight == '0));

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, rst = 1'b0, ID_stall = 1'b0, EX_br_taken = 1'b0;
    logic        imem_gnt = 1'b1, imem_rvld = 1'b0;
    logic [31:0] EX_br_target = '0, imem_rdata = '0;
    logic        imem_req, IF_ID_vld;
    logic [31:0] imem_addr, IF_ID_pc, IF_ID_inst;
`ifdef IF_JAL_PREDICT_EN
    logic        IF_ID_pred;
`endif

    int          n_checks = 0, n_fail = 0;
    logic [31:0] pend[$];
    bit          hold_rsp = 1'b0, jal_mode = 1'b0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .ID_stall(ID_stall),
        .EX_br_taken(EX_br_taken), .EX_br_target(EX_br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvld(imem_rvld), .imem_rdata(imem_rdata),
        .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst),
`ifdef IF_JAL_PREDICT_EN
        .IF_ID_pred(IF_ID_pred),
`endif
        .IF_ID_vld(IF_ID_vld)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (jal_mode && a == 32'h8) ? 32'h0400_006F : ((a << 5) | 32'h13);
    endfunction

    // One clock: in-order memory with >=1 cycle latency, response held back while hold_rsp.
    task automatic tick();
        bit f, r;
        logic [31:0] a;
        f = imem_req && imem_gnt;
        a = imem_addr;
        r = imem_rvld;
        @(posedge clk);
        #1;
        if (!rst) pend.delete();
        else begin
            if (r && pend.size() > 0) void'(pend.pop_front());
            if (f) pend.push_back(a);
        end
        imem_rvld  = rst && !hold_rsp && pend.size() > 0;
        imem_rdata = imem_rvld ? memw(pend[0]) : 32'h0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; ID_stall = 1'b0; EX_br_taken = 1'b0; hold_rsp = 1'b0; jal_mode = 1'b0;
        tick(); tick();
        rst = 1'b1; #1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; ID_stall = 1'b0; EX_br_taken = 1'b0;
        tick(); tick();
        n_checks++; if (IF_ID_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld got %b exp 0", IF_ID_vld); end
        n_checks++; if (IF_ID_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", IF_ID_pc); end
        n_checks++; if (IF_ID_inst !== NOP) begin n_fail++; $display("FAIL rst_inst got %h exp %h", IF_ID_inst, NOP); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", imem_req); end
        rst = 1'b1; #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b exp 0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req got %b/%h exp 1/0", imem_req, imem_addr); end
        tick(); tick(); tick(); tick();
        n_checks++; if (IF_ID_vld !== 1'b1 || IF_ID_pc !== 32'h4) begin n_fail++; $display("FAIL pre_midrst got %b/%h exp 1/4", IF_ID_vld, IF_ID_pc); end
        rst = 1'b0;
        tick();
        n_checks++; if (IF_ID_vld !== 1'b0 || IF_ID_pc !== 32'h0 || IF_ID_inst !== NOP || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL midrst got vld=%b pc=%h inst=%h req=%b exp 0/0/%h/0", IF_ID_vld, IF_ID_pc, IF_ID_inst, imem_req, NOP);
        end
        rst = 1'b1; #1;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_restart got %b/%h exp 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_fetch();
        bit          e_req [7] = '{1, 1, 0, 1, 1, 0, 1};
        logic [31:0] e_addr[7] = '{32'h0, 32'h4, 32'h0, 32'h8, 32'hC, 32'h0, 32'h10};
        bit          e_vld [7] = '{0, 0, 0, 1, 1, 0, 1};
        logic [31:0] e_pc  [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
        logic [31:0] e_inst;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            e_inst = e_vld[i] ? memw(e_pc[i]) : NOP;
            n_checks++; if (imem_req !== e_req[i]) begin n_fail++; $display("FAIL fetch_req c%0d got %b exp %b", i + 1, imem_req, e_req[i]); end
            if (e_req[i]) begin
                n_checks++; if (imem_addr !== e_addr[i]) begin n_fail++; $display("FAIL fetch_addr c%0d got %h exp %h", i + 1, imem_addr, e_addr[i]); end
            end
            n_checks++; if (IF_ID_vld !== e_vld[i]) begin n_fail++; $display("FAIL fetch_vld c%0d got %b exp %b", i + 1, IF_ID_vld, e_vld[i]); end
            n_checks++; if (IF_ID_pc !== e_pc[i]) begin n_fail++; $display("FAIL fetch_pc c%0d got %h exp %h", i + 1, IF_ID_pc, e_pc[i]); end
            n_checks++; if (IF_ID_inst !== e_inst) begin n_fail++; $display("FAIL fetch_inst c%0d got %h exp %h", i + 1, IF_ID_inst, e_inst); end
            tick();
        end
    endtask

    task automatic test_stall();
        bit          e_req[6] = '{1, 1, 0, 0, 0, 0};
        int          nacc = 0;
        bit          was_stall;
        logic [31:0] hp, hi;
        logic        hv;
        do_reset();
        ID_stall = 1'b1; #1;
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (imem_req !== e_req[i]) begin n_fail++; $display("FAIL stall_req c%0d got %b exp %b", i + 1, imem_req, e_req[i]); end
            n_checks++; if (IF_ID_vld !== 1'b0 || IF_ID_inst !== NOP) begin n_fail++; $display("FAIL stall_frozen c%0d got %b/%h exp 0/%h", i + 1, IF_ID_vld, IF_ID_inst, NOP); end
            tick();
        end
        for (int j = 0; j < 14; j++) begin
            ID_stall = (j % 3 == 1); #1;
            if (IF_ID_vld && !ID_stall) begin
                n_checks++; if (IF_ID_pc !== 32'(nacc * 4)) begin n_fail++; $display("FAIL stall_order got %h exp %h", IF_ID_pc, 32'(nacc * 4)); end
                n_checks++; if (IF_ID_inst !== memw(IF_ID_pc)) begin n_fail++; $display("FAIL stall_data got %h exp %h", IF_ID_inst, memw(IF_ID_pc)); end
                nacc++;
            end
            was_stall = ID_stall; hp = IF_ID_pc; hv = IF_ID_vld; hi = IF_ID_inst;
            tick();
            if (was_stall) begin
                n_checks++; if (IF_ID_pc !== hp || IF_ID_vld !== hv || IF_ID_inst !== hi) begin
                    n_fail++; $display("FAIL stall_hold got %h/%b/%h exp %h/%b/%h", IF_ID_pc, IF_ID_vld, IF_ID_inst, hp, hv, hi);
                end
            end
        end
        ID_stall = 1'b0;
        n_checks++; if (nacc < 4) begin n_fail++; $display("FAIL stall_count got %0d exp >=4", nacc); end
    endtask

    // Reaches cycle 3 with two requests (0x0, 0x4) outstanding and no response yet.
    task automatic two_outstanding();
        do_reset();
        hold_rsp = 1'b1;
        tick(); tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL credit_full_req got %b exp 0", imem_req); end
    endtask

    task automatic wait_first_vld(input string nm, input logic [31:0] exp_pc);
        int k = 0;
        while (!IF_ID_vld && k < 10) begin tick(); k++; end
        n_checks++;
        if (!IF_ID_vld) begin n_fail++; $display("FAIL %s_timeout got vld=0 exp vld=1", nm); end
        else if (IF_ID_pc !== exp_pc || IF_ID_inst !== memw(exp_pc)) begin
            n_fail++; $display("FAIL %s_first got %h/%h exp %h/%h", nm, IF_ID_pc, IF_ID_inst, exp_pc, memw(exp_pc));
        end
    endtask

    task automatic test_redirect();
        two_outstanding();
        hold_rsp = 1'b0; EX_br_taken = 1'b1; EX_br_target = 32'h100; #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req got %b exp 0", imem_req); end
        tick();
        EX_br_taken = 1'b0; #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (imem_req !== 1'b0 || IF_ID_vld !== 1'b0) begin n_fail++; $display("FAIL redir_flush c%0d got req=%b vld=%b exp 0/0", i, imem_req, IF_ID_vld); end
            tick();
        end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got %b/%h exp 1/100", imem_req, imem_addr); end
        tick(); tick();
        n_checks++; if (IF_ID_vld !== 1'b0) begin n_fail++; $display("FAIL redir_early_vld got %b exp 0", IF_ID_vld); end
        tick();
        n_checks++; if (IF_ID_vld !== 1'b1 || IF_ID_pc !== 32'h100) begin n_fail++; $display("FAIL redir_arrive got %b/%h exp 1/100", IF_ID_vld, IF_ID_pc); end
    endtask

    task automatic test_redirect_in_flush();
        two_outstanding();
        hold_rsp = 1'b0; EX_br_taken = 1'b1; EX_br_target = 32'h100; #1;
        tick();
        EX_br_target = 32'h200; #1;
        n_checks++; if (imem_req !== 1'b0 || imem_rvld !== 1'b1) begin n_fail++; $display("FAIL flush_redir_pre got req=%b rvld=%b exp 0/1", imem_req, imem_rvld); end
        tick();
        EX_br_taken = 1'b0; #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_redir_wait got %b exp 0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL flush_redir_addr got %b/%h exp 1/200", imem_req, imem_addr); end
        wait_first_vld("flush_redir", 32'h200);
    endtask

    task automatic test_redirect_rvld_align();
        two_outstanding();
        hold_rsp = 1'b0;
        tick();
        EX_br_taken = 1'b1; EX_br_target = 32'h103; #1;
        n_checks++; if (imem_rvld !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL align_pre got rvld=%b req=%b exp 1/0", imem_rvld, imem_req); end
        tick();
        EX_br_taken = 1'b0; #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL align_drop1 got %b exp 0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL align_addr got %b/%h exp 1/100", imem_req, imem_addr); end
        wait_first_vld("align", 32'h100);
    endtask

    task automatic test_redirect_stall();
        do_reset();
        tick(); tick(); tick(); tick();
        n_checks++; if (IF_ID_vld !== 1'b1 || imem_rvld !== 1'b1) begin n_fail++; $display("FAIL rs_pre got vld=%b rvld=%b exp 1/1", IF_ID_vld, imem_rvld); end
        ID_stall = 1'b1; EX_br_taken = 1'b1; EX_br_target = 32'h40; #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rs_req got %b exp 0", imem_req); end
        tick();
        EX_br_taken = 1'b0; #1;
        n_checks++; if (IF_ID_vld !== 1'b0 || IF_ID_inst !== NOP) begin n_fail++; $display("FAIL rs_kill got %b/%h exp 0/%h", IF_ID_vld, IF_ID_inst, NOP); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL rs_nodrop got %b/%h exp 1/40", imem_req, imem_addr); end
        ID_stall = 1'b0; #1;
        wait_first_vld("rs", 32'h40);
    endtask

`ifdef IF_JAL_PREDICT_EN
    task automatic test_jal();
        do_reset();
        jal_mode = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        n_checks++; if (IF_ID_pred !== 1'b0 || IF_ID_pc !== 32'h4) begin n_fail++; $display("FAIL jal_pre got pred=%b pc=%h exp 0/4", IF_ID_pred, IF_ID_pc); end
        tick();
        n_checks++; if (IF_ID_vld !== 1'b1 || IF_ID_pc !== 32'h8 || IF_ID_inst !== 32'h0400_006F || IF_ID_pred !== 1'b1) begin
            n_fail++; $display("FAIL jal_present got %b/%h/%h/%b exp 1/8/0400006f/1", IF_ID_vld, IF_ID_pc, IF_ID_inst, IF_ID_pred);
        end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h48) begin n_fail++; $display("FAIL jal_target got %b/%h exp 1/48", imem_req, imem_addr); end
        tick();
        n_checks++; if (IF_ID_pred !== 1'b0) begin n_fail++; $display("FAIL jal_pred_clr got %b exp 0", IF_ID_pred); end
        wait_first_vld("jal", 32'h48);
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_redirect_in_flush();
        test_redirect_rvld_align();
        test_redirect_stall();
`ifdef IF_JAL_PREDICT_EN
        test_jal();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
